// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-bit signed-magnitude to 4-digit multiplexed 7-segment driver (optional LEADING_ZERO_BLANK_EN)
module seg_scan_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       neg,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);

    state_t      state, state_nxt;
    logic        start, update;
    logic [7:0]  shreg;
    logic        cap_neg;
    logic [11:0] bcd, bcd_adj;
    logic [2:0]  bit_cnt;

    logic [3:0]  disp_h, disp_t, disp_o;
    logic        disp_neg;
    logic [3:0]  h_nxt, t_nxt, o_nxt;
    logic        neg_nxt;
    logic [15:0] presc, presc_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        blank_h, blank_t;
    logic [6:0]  seg_nxt;
    logic [3:0]  an_nxt;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (bit_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        start  = (state == IDLE) && load;
        update = (state == DONE);
    end

    // Double-dabble: correct each BCD nibble before shifting in the next value bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= 8'd0;
            cap_neg <= 1'b0;
            bcd     <= 12'd0;
            bit_cnt <= 3'd0;
        end else if (start) begin
            shreg   <= value;
            cap_neg <= neg;
            bcd     <= 12'd0;
            bit_cnt <= 3'd0;
        end else if (state == CONV) begin
            bcd     <= {bcd_adj[10:0], shreg[7]};
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // seg/an are computed from next-state scan and display values so a
    // display update landing on a slot change appears in the new slot.
    always_comb begin
        presc_nxt = (presc == PRESC_MAX) ? 16'd0 : presc + 16'd1;
        idx_nxt   = (presc == PRESC_MAX) ? idx + 2'd1 : idx;
        h_nxt     = update ? bcd[11:8] : disp_h;
        t_nxt     = update ? bcd[7:4]  : disp_t;
        o_nxt     = update ? bcd[3:0]  : disp_o;
        neg_nxt   = update ? cap_neg   : disp_neg;
`ifdef LEADING_ZERO_BLANK_EN
        blank_h   = (h_nxt == 4'd0);
        blank_t   = blank_h && (t_nxt == 4'd0);
`else
        blank_h   = 1'b0;
        blank_t   = 1'b0;
`endif
        an_nxt    = ~(4'b0001 << idx_nxt);
        case (idx_nxt)
            2'd0:    seg_nxt = encode(o_nxt);
            2'd1:    seg_nxt = blank_t ? 7'b1111111 : encode(t_nxt);
            2'd2:    seg_nxt = blank_h ? 7'b1111111 : encode(h_nxt);
            default: seg_nxt = neg_nxt ? 7'b0111111 : 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= 16'd0;
            idx      <= 2'd0;
            disp_h   <= 4'd0;
            disp_t   <= 4'd0;
            disp_o   <= 4'd0;
            disp_neg <= 1'b0;
            seg      <= 7'b1000000;
            an       <= 4'b1110;
        end else begin
            presc    <= presc_nxt;
            idx      <= idx_nxt;
            disp_h   <= h_nxt;
            disp_t   <= t_nxt;
            disp_o   <= o_nxt;
            disp_neg <= neg_nxt;
            seg      <= seg_nxt;
            an       <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed scoreboard bench for seg_scan_driver (REFRESH_DIV=4)
module tb_seg_scan_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] value;
    logic       neg;
    logic       load;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [10:0] sb_q[$];
    int m_h, m_t, m_o;
    logic m_neg;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .neg   (neg),
        .load  (load),
        .busy  (busy),
        .seg   (seg),
        .an    (an)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] slot_exp(input int s);
        bit bh, bt;
`ifdef LEADING_ZERO_BLANK_EN
        bh = (m_h == 0);
        bt = bh && (m_t == 0);
`else
        bh = 1'b0;
        bt = 1'b0;
`endif
        case (s)
            0: return seg_of(m_o);
            1: return bt ? 7'b1111111 : seg_of(m_t);
            2: return bh ? 7'b1111111 : seg_of(m_h);
            default: return m_neg ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_model(input int h, input int t, input int o, input logic n);
        m_h = h; m_t = t; m_o = o; m_neg = n;
    endtask

    task automatic scan_check(input string tag, input int n);
        int s;
        logic [3:0] a;
        logic [10:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s = (cyc / DIV) % 4;
            a = 4'b0001 << s;
            sb_q.push_back({~a, slot_exp(s)});
            e = sb_q.pop_front();
            chk(tag, {21'd0, an, seg}, {21'd0, e});
        end
    endtask

    // extra_at: negedge index at which a second (ignored) load is pulsed; rst_at: index to abort with reset
    task automatic run_load(input string tag, input logic [7:0] v, input logic n,
                            input int extra_at, input int rst_at);
        int nb;
        nb = 0;
        @(negedge clk);
        value = v; neg = n; load = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) load = 1'b0;
            if (i == extra_at) begin value = 8'd3; load = 1'b1; end
            if (i == extra_at + 1) load = 1'b0;
            if (i == rst_at) begin
                chk({tag, "_busy_pre_rst"}, {31'd0, busy}, 32'd1);
                rst_n = 1'b0;
                #1;
                chk({tag, "_busy_abort"}, {31'd0, busy}, 32'd0);
                chk({tag, "_seg_abort"}, {25'd0, seg}, {25'd0, 7'b1000000});
                chk({tag, "_an_abort"}, {28'd0, an}, {28'd0, 4'b1110});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (busy) nb++;
        end
        chk({tag, "_busy_cycles"}, nb, 9);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; value = 8'd0; neg = 1'b0;
        set_model(0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        chk("rst_an", {28'd0, an}, {28'd0, 4'b1110});
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_spurious_load", {31'd0, busy}, 32'd0);
        scan_check("scan_reset", 16);

        run_load("ld225", 8'd225, 1'b0, -10, -1);
        set_model(2, 2, 5, 1'b0);
        scan_check("scan_225", 16);

        run_load("ld7n", 8'd7, 1'b1, -10, -1);
        set_model(0, 0, 7, 1'b1);
        scan_check("scan_7n", 16);

        run_load("ld99", 8'd99, 1'b0, 2, -1);
        set_model(0, 9, 9, 1'b0);
        scan_check("scan_99", 16);

        run_load("ld255", 8'd255, 1'b0, -10, 4);
        set_model(0, 0, 0, 1'b0);
        scan_check("scan_abort", 16);

        run_load("ld10", 8'd10, 1'b0, -10, -1);
        set_model(0, 1, 0, 1'b0);
        scan_check("scan_10", 8);
        value = 8'd200; neg = 1'b1;
        scan_check("scan_hold", 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
